alu_wb_stage: RTL and testbench

Execute-to-writeback stage directly downstream of the 16-bit ALU. Captures each ALU result and its S/Z/C/V flags into a one-entry pipeline register with valid/ready handshake. Owns the architectural flag register, evaluates branch conditions against it with same-cycle bypass, and counts retired instructions. Feeds the register-file write port and the branch/PC unit.

---
 rtl/alu_wb_stage_if.sv | 32 +++
 rtl/alu_wb_stage.sv | 142 ++++++++++++++
 tb/tb_alu_wb_stage.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_wb_stage_if.sv
// Execute/writeback bus bundle for alu_wb_stage.
// The slave modport is the stage's own view. The master modport is the
// surrounding pipeline's view: the ALU drives the ex side, and the
// register-file writer consumes the wb side.
interface alu_wb_stage_if #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 3
);
    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] ex_res;
    logic [3:0]        ex_szcv;
    logic [RD_W-1:0]   ex_rd;
    logic              ex_we;
    logic              ex_flag_we;

    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_res;
    logic [RD_W-1:0]   wb_rd;
    logic              wb_we;

    modport slave (
        input  ex_valid, ex_res, ex_szcv, ex_rd, ex_we, ex_flag_we, wb_ready,
        output ex_ready, wb_valid, wb_res, wb_rd, wb_we
    );

    modport master (
        output ex_valid, ex_res, ex_szcv, ex_rd, ex_we, ex_flag_we, wb_ready,
        input  ex_ready, wb_valid, wb_res, wb_rd, wb_we
    );
endinterface

// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage. It holds one ALU result for the register-file
// write port and owns the architectural S/Z/C/V flag register. It also
// resolves branch conditions, forwarding flags that are written in the same
// cycle, and counts retired entries.
module alu_wb_stage #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 3,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_wb_stage_if.slave    bus,
    input  logic             flush_i,
    input  logic             br_req_i,
    input  logic [2:0]       br_cond_i,
    output logic [3:0]       flags_o,
    output logic             br_valid_o,
    output logic             br_taken_o,
    output logic [CNT_W-1:0] retire_cnt_o
);

    // Branch condition codes.
    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;
    localparam logic [2:0] COND_B   = 3'b100;

    logic              wb_valid_q,   wb_valid_d;
    logic [DATA_W-1:0] wb_res_q,     wb_res_d;
    logic [RD_W-1:0]   wb_rd_q,      wb_rd_d;
    logic              wb_we_q,      wb_we_d;
    logic [3:0]        flags_q,      flags_d;
    logic              br_valid_q,   br_valid_d;
    logic              br_taken_q,   br_taken_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

    logic              ex_ready_s;
    logic              acc_s;
    logic              retire_s;
    logic [3:0]        eff_flags_s;

    // Evaluate a condition code against a {S,Z,C,V} flag vector.
    function automatic logic cond_eval(input logic [2:0] cond, input logic [3:0] f);
        logic s_v;
        logic z_v;
        logic v_v;
        logic res_v;
        s_v = f[3];
        z_v = f[2];
        v_v = f[0];
        case (cond)
            COND_BE:  res_v = z_v;
            COND_BLT: res_v = s_v ^ v_v;
            COND_BLE: res_v = z_v | (s_v ^ v_v);
            COND_BNE: res_v = ~z_v;
            COND_B:   res_v = 1'b1;
            default:  res_v = 1'b0;
        endcase
        return res_v;
    endfunction

    assign ex_ready_s = ~wb_valid_q | bus.wb_ready;
    assign acc_s      = bus.ex_valid & ex_ready_s & ~flush_i;
    // A retire is suppressed by flush. The held entry is discarded instead.
    assign retire_s   = wb_valid_q & bus.wb_ready & ~flush_i;
    // Same-cycle bypass: a branch evaluated alongside a flag-writing accept
    // sees the new flags.
    assign eff_flags_s = (acc_s & bus.ex_flag_we) ? bus.ex_szcv : flags_q;

    // Next-state logic for the pipeline register, flags, branch and counter.
    always_comb begin
        wb_valid_d   = wb_valid_q;
        wb_res_d     = wb_res_q;
        wb_rd_d      = wb_rd_q;
        wb_we_d      = wb_we_q;
        flags_d      = flags_q;
        retire_cnt_d = retire_cnt_q;

        if (flush_i) begin
            wb_valid_d = 1'b0;
        end else if (acc_s) begin
            wb_valid_d = 1'b1;
            wb_res_d   = bus.ex_res;
            wb_rd_d    = bus.ex_rd;
            wb_we_d    = bus.ex_we;
        end else if (wb_valid_q & bus.wb_ready) begin
            wb_valid_d = 1'b0;
        end else begin
            wb_valid_d = wb_valid_q;
        end

        if (acc_s & bus.ex_flag_we) begin
            flags_d = bus.ex_szcv;
        end else begin
            flags_d = flags_q;
        end

        if (retire_s) begin
            retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retire_cnt_d = retire_cnt_q;
        end

        br_valid_d = br_req_i;
        br_taken_d = br_req_i & cond_eval(br_cond_i, eff_flags_s);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid_q   <= 1'b0;
            wb_res_q     <= {DATA_W{1'b0}};
            wb_rd_q      <= {RD_W{1'b0}};
            wb_we_q      <= 1'b0;
            flags_q      <= 4'b0000;
            br_valid_q   <= 1'b0;
            br_taken_q   <= 1'b0;
            retire_cnt_q <= {CNT_W{1'b0}};
        end else begin
            wb_valid_q   <= wb_valid_d;
            wb_res_q     <= wb_res_d;
            wb_rd_q      <= wb_rd_d;
            wb_we_q      <= wb_we_d;
            flags_q      <= flags_d;
            br_valid_q   <= br_valid_d;
            br_taken_q   <= br_taken_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign bus.ex_ready = ex_ready_s;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_res   = wb_res_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_we    = wb_we_q;
    assign flags_o      = flags_q;
    assign br_valid_o   = br_valid_q;
    assign br_taken_o   = br_taken_q;
    assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_alu_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        br_req;
    logic [2:0]  br_cond;
    logic [3:0]  flags;
    logic        br_valid;
    logic        br_taken;
    logic [15:0] retire_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    alu_wb_stage_if #(.DATA_W(16), .RD_W(3)) bus ();

    alu_wb_stage #(.DATA_W(16), .RD_W(3), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .flush_i      (flush),
        .br_req_i     (br_req),
        .br_cond_i    (br_cond),
        .flags_o      (flags),
        .br_valid_o   (br_valid),
        .br_taken_o   (br_taken),
        .retire_cnt_o (retire_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  rd;
        logic        we;
    } ent_t;

    ent_t        q[$];      // entries held for writeback (0 or 1)
    ent_t        m_last;    // most recently loaded fields
    logic [3:0]  m_flags;
    logic        m_brv;
    logic        m_brt;
    logic [15:0] m_cnt;

    function automatic logic ref_cond(input logic [2:0] c, input logic [3:0] f);
        logic r;
        case (c)
            3'd0:    r = f[2];
            3'd1:    r = f[3] ^ f[0];
            3'd2:    r = f[2] | (f[3] ^ f[0]);
            3'd3:    r = !f[2];
            3'd4:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    task automatic model_step();
        logic       rdy;
        logic       acc;
        logic [3:0] eff;
        ent_t       e;
        rdy = (q.size() == 0) || bus.wb_ready;
        acc = bus.ex_valid && rdy && !flush;
        if (!rst_n) begin
            q.delete();
            m_last  = '0;
            m_flags = 4'h0;
            m_brv   = 1'b0;
            m_brt   = 1'b0;
            m_cnt   = 16'h0;
        end else begin
            eff   = (acc && bus.ex_flag_we) ? bus.ex_szcv : m_flags;
            m_brv = br_req;
            m_brt = br_req && ref_cond(br_cond, eff);
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() > 0 && bus.wb_ready) begin
                    void'(q.pop_front());
                    m_cnt = m_cnt + 16'd1;
                end
                if (acc) begin
                    e.res = bus.ex_res; e.rd = bus.ex_rd; e.we = bus.ex_we;
                    q.push_back(e);
                    m_last = e;
                end
            end
            if (acc && bus.ex_flag_we) m_flags = bus.ex_szcv;
        end
    endtask

    // Drive all inputs just after a falling edge.
    task automatic drive(input logic rn, input logic v, input logic [15:0] res,
                         input logic [3:0] szcv, input logic [2:0] rd, input logic we,
                         input logic fwe, input logic fl, input logic brq,
                         input logic [2:0] bc, input logic wbr);
        @(negedge clk);
        rst_n = rn; bus.ex_valid = v; bus.ex_res = res; bus.ex_szcv = szcv;
        bus.ex_rd = rd; bus.ex_we = we; bus.ex_flag_we = fwe; flush = fl;
        br_req = brq; br_cond = bc; bus.wb_ready = wbr;
    endtask

    // Advance one rising edge and update the model; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1'b0, 1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        tick();
        drive(1'b1, 1'b1, 16'hABCD, 4'hA, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0);
        tick();
        // Reset while a new entry and a flag write are presented.
        drive(1'b0, 1'b1, 16'h5555, 4'hF, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0);
        tick();
        n_tests++;
        if ({bus.wb_valid, bus.wb_res, bus.wb_rd, bus.wb_we, flags, br_valid, br_taken, retire_cnt} !== 43'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got wbv=%b res=%h rd=%h we=%b flags=%h brv=%b brt=%b cnt=%h want all 0",
                     bus.wb_valid, bus.wb_res, bus.wb_rd, bus.wb_we, flags, br_valid, br_taken, retire_cnt);
        end
        drive(1'b1, 1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        #1;
        n_tests++;
        if (bus.ex_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ex_ready got %b want 1", bus.ex_ready);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_seq [3];
        exp_seq[0] = 16'h0001; exp_seq[1] = 16'h0002; exp_seq[2] = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, exp_seq[i], 4'h0, 3'(i), 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
            tick();
            n_tests++;
            if (bus.wb_valid !== 1'b1 || bus.wb_res !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL b2b_res%0d got v=%b res=%h want v=1 res=%h", i, bus.wb_valid, bus.wb_res, exp_seq[i]);
            end
        end
        drive(1'b1, 1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        tick();
        n_tests++;
        if (retire_cnt !== 16'd3 || bus.wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_count got cnt=%0d v=%b want cnt=3 v=0", retire_cnt, bus.wb_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] c0;
        c0 = m_cnt;
        drive(1'b1, 1'b1, 16'h1234, 4'h0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 16'h5678, 4'h0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
            #1;
            n_tests++;
            if (bus.ex_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_ex_ready%0d got %b want 0", i, bus.ex_ready);
            end
            tick();
            n_tests++;
            if (bus.wb_valid !== 1'b1 || bus.wb_res !== 16'h1234 || bus.wb_rd !== 3'd1) begin
                n_fail++;
                $display("FAIL bp_hold%0d got v=%b res=%h rd=%0d want v=1 res=1234 rd=1", i, bus.wb_valid, bus.wb_res, bus.wb_rd);
            end
        end
        drive(1'b1, 1'b1, 16'h5678, 4'h0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        tick();
        n_tests++;
        if (bus.wb_res !== 16'h5678 || retire_cnt !== c0 + 16'd1) begin
            n_fail++; $display("FAIL bp_release got res=%h cnt=%0d want res=5678 cnt=%0d", bus.wb_res, retire_cnt, c0 + 16'd1);
        end
        drive(1'b1, 1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        tick();
        n_tests++;
        if (bus.wb_valid !== 1'b0 || retire_cnt !== c0 + 16'd2) begin
            n_fail++; $display("FAIL bp_drain got v=%b cnt=%0d want v=0 cnt=%0d", bus.wb_valid, retire_cnt, c0 + 16'd2);
        end
    endtask

    task automatic test_bypass();
        logic [2:0] conds [2];
        logic       want [2];
        conds[0] = 3'd0; want[0] = 1'b1;   // BE
        conds[1] = 3'd3; want[1] = 1'b0;   // BNE
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 16'h0, 4'b0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
            tick();
            drive(1'b1, 1'b1, 16'h0, 4'b0100, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, conds[i], 1'b1);
            tick();
            n_tests++;
            if (br_valid !== 1'b1 || br_taken !== want[i] || flags !== 4'b0100) begin
                n_fail++;
                $display("FAIL bypass_c%0d got brv=%b brt=%b flags=%b want brv=1 brt=%b flags=0100",
                         conds[i], br_valid, br_taken, flags, want[i]);
            end
        end
    endtask

    task automatic test_blt_ble();
        logic [3:0] fl   [3];
        logic [2:0] cd   [3];
        logic       want [3][3];
        fl[0] = 4'b1000; fl[1] = 4'b1001; fl[2] = 4'b1000;
        cd[0] = 3'd1;    cd[1] = 3'd2;    cd[2] = 3'd7;
        want[0][0] = 1'b1; want[0][1] = 1'b1; want[0][2] = 1'b0;
        want[1][0] = 1'b0; want[1][1] = 1'b0; want[1][2] = 1'b0;
        want[2][0] = 1'b1; want[2][1] = 1'b1; want[2][2] = 1'b0;
        for (int f = 0; f < 3; f++) begin
            drive(1'b1, 1'b1, 16'h0, fl[f], 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
            tick();
            for (int c = 0; c < 3; c++) begin
                drive(1'b1, 1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, cd[c], 1'b1);
                tick();
                n_tests++;
                if (br_valid !== 1'b1 || br_taken !== want[f][c]) begin
                    n_fail++;
                    $display("FAIL cond_f%b_c%0d got brv=%b brt=%b want brv=1 brt=%b",
                             fl[f], cd[c], br_valid, br_taken, want[f][c]);
                end
            end
        end
        drive(1'b1, 1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1);
        tick();
        n_tests++;
        if (br_valid !== 1'b0 || br_taken !== 1'b0) begin
            n_fail++; $display("FAIL br_idle got brv=%b brt=%b want 0 0", br_valid, br_taken);
        end
    endtask

    task automatic test_flush();
        logic [3:0]  f0;
        logic [15:0] c0;
        drive(1'b1, 1'b1, 16'h0BAD, 4'h2, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        tick();
        f0 = m_flags; c0 = m_cnt;
        drive(1'b1, 1'b1, 16'hFFFF, 4'b1111, 3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1);
        tick();
        n_tests++;
        if (bus.wb_valid !== 1'b0 || flags !== f0 || retire_cnt !== c0 || br_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL flush got v=%b flags=%b cnt=%0d brt=%b want v=0 flags=%b cnt=%0d brt=1",
                     bus.wb_valid, flags, retire_cnt, br_taken, f0, c0);
        end
    endtask

    task automatic test_random();
        logic wbr;
        for (int i = 0; i < 400; i++) begin
            wbr = ($urandom_range(9, 0) < 7);
            drive(($urandom_range(49, 0) != 0), 1'($urandom), 16'($urandom), 4'($urandom),
                  3'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(9, 0) == 0),
                  1'($urandom), 3'($urandom), wbr);
            #1;
            n_tests++;
            if (bus.ex_ready !== ((q.size() == 0) || wbr)) begin
                n_fail++; $display("FAIL rnd_ex_ready@%0d got %b want %b", i, bus.ex_ready, (q.size() == 0) || wbr);
            end
            tick();
            n_tests++;
            if (bus.wb_valid !== (q.size() != 0) || bus.wb_res !== m_last.res || bus.wb_rd !== m_last.rd ||
                bus.wb_we !== m_last.we || flags !== m_flags || br_valid !== m_brv ||
                br_taken !== m_brt || retire_cnt !== m_cnt) begin
                n_fail++;
                $display("FAIL rnd_state@%0d got v=%b res=%h rd=%0d we=%b fl=%b brv=%b brt=%b cnt=%0d want v=%b res=%h rd=%0d we=%b fl=%b brv=%b brt=%b cnt=%0d",
                         i, bus.wb_valid, bus.wb_res, bus.wb_rd, bus.wb_we, flags, br_valid, br_taken, retire_cnt,
                         q.size() != 0, m_last.res, m_last.rd, m_last.we, m_flags, m_brv, m_brt, m_cnt);
            end
        end
    endtask

    task automatic test_wrap();
        int budget;
        budget = 0;
        while (m_cnt != 16'hFFFF && budget < 70000) begin
            drive(1'b1, 1'b1, 16'(budget), 4'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
            tick();
            budget++;
        end
        n_tests++;
        if (retire_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL wrap_preset got %h want ffff (budget %0d)", retire_cnt, budget);
        end
        drive(1'b1, 1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        tick();
        n_tests++;
        if (retire_cnt !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_zero got %h want 0000", retire_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; br_req = 1'b0; br_cond = 3'd0;
        bus.ex_valid = 1'b0; bus.ex_res = 16'h0; bus.ex_szcv = 4'h0; bus.ex_rd = 3'd0;
        bus.ex_we = 1'b0; bus.ex_flag_we = 1'b0; bus.wb_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_bypass();
        test_blt_ble();
        test_flush();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
